// File: rtl/bus_memory_responder.sv
// Word-organised main-memory model answering the data-cache bus with programmable wait states.
// Define BUS_RESP_RANGE_CHECK_EN to flag out-of-range addresses with HError instead of aliasing.
module bus_memory_responder #(
    parameter int depth      = 1024,
    parameter int waitstates = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HRequest,
    input  logic        HWrite,
    input  logic [31:0] HAddr,
    input  logic [31:0] HWData,
    output logic [31:0] HRData,
    output logic        BusReady,
    output logic        HError
);
    localparam int         addrbits  = $clog2(depth);
    localparam logic [3:0] wait_load = 4'(waitstates);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [3:0]          count;
    logic [3:0]          next_count;
    logic                accept;
    logic                commit;
    logic                req_err;

    logic [addrbits-1:0] lat_index;
    logic                lat_write;
    logic [31:0]         lat_data;
    logic                lat_err;

    logic [31:0]         mem [depth];

    // Byte-lane bits never select anything; upper bits only matter to the range check.
    logic                unused_addr;
    assign unused_addr = ^{HAddr[1:0], HAddr[31:addrbits+2]};

`ifdef BUS_RESP_RANGE_CHECK_EN
    assign req_err = |HAddr[31:addrbits+2];
`else
    assign req_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        next_count = count;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (HRequest) begin
                    accept     = 1'b1;
                    next_count = wait_load;
                    next_state = (wait_load == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // A withdrawn request abandons the transfer before anything is committed.
                if (!HRequest) begin
                    next_state = IDLE;
                    next_count = 4'd0;
                end else begin
                    next_count = count - 4'd1;
                    if (count == 4'd1) begin
                        next_state = RESP;
                    end
                end
            end
            RESP: begin
                commit     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_count = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Request capture: later HAddr/HWData movement during WAIT has no effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_index <= HAddr[addrbits+1:2];
            lat_write <= HWrite;
            lat_data  <= HWData;
            lat_err   <= req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && commit && lat_write && !lat_err) begin
            mem[lat_index] <= lat_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BusReady <= 1'b0;
            HRData   <= 32'h0;
        end else begin
            BusReady <= commit;
            if (commit && !lat_write) begin
                HRData <= lat_err ? 32'hDEADBEEF : mem[lat_index];
            end
        end
    end

`ifdef BUS_RESP_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HError <= 1'b0;
        end else begin
            HError <= commit && lat_err;
        end
    end
`else
    assign HError = 1'b0;
`endif

endmodule
